// File: rtl/adder_tree_pkg.sv
// -----------------------------------------------------------------------------
// adder_tree_pkg
// Shared definitions for the pipelined adder tree:
//   - clog2         : ceiling log2 used to derive the tree depth
//   - calc_out_w    : result width (tree growth plus optional accumulator bits)
//   - acc_state_t   : accumulator FSM state encoding
// No ports; imported by pipelined_adder_tree.
// -----------------------------------------------------------------------------
package adder_tree_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      ACC  = 1'b1
   } acc_state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result++;
      end
      return result;
   endfunction

   // Each tree level adds one bit, so LEVELS bits of growth cover the full
   // reduction; the accumulator adds ACC_EXTRA bits of frame headroom.
   function automatic int calc_out_w(input int adder_width,
                                     input int num_inputs,
                                     input int accumulate,
                                     input int acc_extra);
      return adder_width + clog2(num_inputs) + ((accumulate != 0) ? acc_extra : 0);
   endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// -----------------------------------------------------------------------------
// adder_tree_stage
// One registered reduction level: ENTRIES lanes of IN_W bits are summed in
// adjacent pairs into ENTRIES/2 lanes of IN_W+1 bits. Valid and last travel
// with the data; everything holds while adv is low.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   adv        : global pipeline advance enable
//   in_data    : ENTRIES packed lanes, lane j at [j*IN_W +: IN_W]
//   in_valid   : predecessor stage valid
//   in_last    : predecessor stage last flag
//   out_data   : registered pairwise sums, lane j at [j*(IN_W+1) +: IN_W+1]
//   out_valid  : this stage valid
//   out_last   : this stage last flag
// -----------------------------------------------------------------------------
module adder_tree_stage #(
   parameter  int IN_W        = 15,
   parameter  int ENTRIES     = 8,
   parameter  int SIGNED      = 0,
   localparam int OUT_ENTRIES = ENTRIES / 2,
   localparam int OUT_W       = IN_W + 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         adv,
   input  logic [ENTRIES*IN_W-1:0]      in_data,
   input  logic                         in_valid,
   input  logic                         in_last,
   output logic [OUT_ENTRIES*OUT_W-1:0] out_data,
   output logic                         out_valid,
   output logic                         out_last
);

   localparam logic SGN = (SIGNED != 0);

   logic [OUT_ENTRIES*OUT_W-1:0] sums;

   // Both operands are widened by one bit before the add, so the sum can
   // never overflow the lane width of this level.
   for (genvar j = 0; j < OUT_ENTRIES; j++) begin : g_pair
      logic [IN_W-1:0] op_a;
      logic [IN_W-1:0] op_b;
      assign op_a = in_data[(2*j)*IN_W +: IN_W];
      assign op_b = in_data[(2*j+1)*IN_W +: IN_W];
      assign sums[j*OUT_W +: OUT_W] = {SGN & op_a[IN_W-1], op_a}
                                    + {SGN & op_b[IN_W-1], op_b};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (adv) begin
         out_data  <= sums;
         out_valid <= in_valid;
         out_last  <= in_last;
      end
   end

endmodule

// File: rtl/pipelined_adder_tree.sv
// -----------------------------------------------------------------------------
// pipelined_adder_tree
// Fully pipelined binary adder tree reducing NUM_INPUTS lanes to one sum per
// beat, with optional frame accumulation after the tree.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_data    : NUM_INPUTS packed lanes, lane i at [i*ADDER_WIDTH +: ADDER_WIDTH]
//   in_valid   : input beat present
//   in_last    : last beat of a frame (only meaningful with ACCUMULATE=1)
//   in_ready   : input beat accepted on an edge with in_valid && in_ready
//   out_sum    : result, OUT_W bits
//   out_valid  : out_sum holds a result
//   out_ready  : downstream accepts the result
//
// Handshake: a transfer happens on a rising edge where valid && ready on that
// interface. The whole pipeline moves as one: adv = out_ready || !out_valid.
// When adv is low every stage (including the input register and the
// accumulator) holds, so in_ready is simply adv. Bubbles are not squeezed out.
// -----------------------------------------------------------------------------
module pipelined_adder_tree
   import adder_tree_pkg::*;
#(
   parameter  int ADDER_WIDTH = 15,
   parameter  int NUM_INPUTS  = 8,
   parameter  int SIGNED      = 0,
   parameter  int ACCUMULATE  = 0,
   parameter  int ACC_EXTRA   = 8,
   localparam int LEVELS      = clog2(NUM_INPUTS),
   localparam int OUT_W       = calc_out_w(ADDER_WIDTH, NUM_INPUTS, ACCUMULATE, ACC_EXTRA)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_INPUTS*ADDER_WIDTH-1:0] in_data,
   input  logic                              in_valid,
   input  logic                              in_last,
   output logic                              in_ready,
   output logic [OUT_W-1:0]                  out_sum,
   output logic                              out_valid,
   input  logic                              out_ready
);

   localparam int TREE_W = ADDER_WIDTH + LEVELS;

   logic adv;
   assign adv      = out_ready || !out_valid;
   assign in_ready = adv;

   // Level 0 is the input register; level k holds NUM_INPUTS>>k lanes of
   // ADDER_WIDTH+k bits produced by one adder_tree_stage.
   for (genvar k = 0; k <= LEVELS; k++) begin : lvl
      localparam int ENTRIES = NUM_INPUTS >> k;
      localparam int EW      = ADDER_WIDTH + k;

      logic [ENTRIES*EW-1:0] data;
      logic                  valid;
      logic                  last;

      if (k == 0) begin : g_input
         always_ff @(posedge clk) begin
            if (rst) begin
               data  <= '0;
               valid <= 1'b0;
               last  <= 1'b0;
            end else if (adv) begin
               data  <= in_data;
               valid <= in_valid;
               last  <= in_last;
            end
         end
      end else begin : g_reduce
         adder_tree_stage #(
            .IN_W    (EW - 1),
            .ENTRIES (ENTRIES * 2),
            .SIGNED  (SIGNED)
         ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .adv       (adv),
            .in_data   (lvl[k-1].data),
            .in_valid  (lvl[k-1].valid),
            .in_last   (lvl[k-1].last),
            .out_data  (data),
            .out_valid (valid),
            .out_last  (last)
         );
      end
   end

   logic [TREE_W-1:0] tree_sum;
   logic              tree_valid;
   logic              tree_last;
   logic [OUT_W-1:0]  tree_ext;

   assign tree_sum   = lvl[LEVELS].data;
   assign tree_valid = lvl[LEVELS].valid;
   assign tree_last  = lvl[LEVELS].last;

   if (SIGNED != 0) begin : g_ext_signed
      assign tree_ext = OUT_W'($signed(tree_sum));
   end else begin : g_ext_unsigned
      assign tree_ext = OUT_W'(tree_sum);
   end

   if (ACCUMULATE == 0) begin : g_direct
      // The last flag has no meaning without the accumulator.
      logic unused_last;
      assign unused_last = tree_last;

      assign out_sum   = tree_ext;
      assign out_valid = tree_valid;
   end else begin : g_accum
      acc_state_t       state;
      acc_state_t       state_next;
      logic [OUT_W-1:0] acc;
      logic [OUT_W-1:0] acc_next;
      logic [OUT_W-1:0] sum_q;
      logic [OUT_W-1:0] sum_next;
      logic             valid_q;
      logic             valid_next;

      always_ff @(posedge clk) begin
         if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            sum_q   <= '0;
            valid_q <= 1'b0;
         end else begin
            state   <= state_next;
            acc     <= acc_next;
            sum_q   <= sum_next;
            valid_q <= valid_next;
         end
      end

      // In IDLE the running total is treated as zero, so a single-beat frame
      // emits its own sum and a new frame starts from its first beat.
      // Additions wrap modulo 2^OUT_W.
      always_comb begin
         state_next = state;
         acc_next   = acc;
         sum_next   = sum_q;
         valid_next = valid_q;
         if (adv) begin
            valid_next = 1'b0;
            if (tree_valid) begin
               if (tree_last) begin
                  sum_next   = ((state == ACC) ? acc : '0) + tree_ext;
                  valid_next = 1'b1;
                  state_next = IDLE;
               end else begin
                  acc_next   = ((state == ACC) ? acc : '0) + tree_ext;
                  state_next = ACC;
               end
            end
         end
      end

      assign out_sum   = sum_q;
      assign out_valid = valid_q;
   end

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder_tree
// Three instances: unsigned tree, signed tree (both fed the same beats) and an
// unsigned accumulating tree with its own handshake. Expected results come from
// a lane-sum reference model and are compared in order as results are consumed.
// -----------------------------------------------------------------------------
module tb_pipelined_adder_tree;

   localparam int W    = 15;
   localparam int N    = 8;
   localparam int DW   = N * W;
   localparam int TW   = 18;
   localparam int AW   = 26;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic [DW-1:0] in_data   = '0;
   logic          in_valid  = 1'b0;
   logic          tree_last = 1'b0;
   logic          out_ready = 1'b1;
   logic          u_in_ready, s_in_ready;
   logic [TW-1:0] u_out_sum, s_out_sum;
   logic          u_out_valid, s_out_valid;

   logic [DW-1:0] a_in_data   = '0;
   logic          a_in_valid  = 1'b0;
   logic          a_in_last   = 1'b0;
   logic          a_out_ready = 1'b1;
   logic          a_in_ready;
   logic [AW-1:0] a_out_sum;
   logic          a_out_valid;

   pipelined_adder_tree #(.ADDER_WIDTH(W), .NUM_INPUTS(N), .SIGNED(0), .ACCUMULATE(0)) dut_u (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(tree_last),
      .in_ready(u_in_ready), .out_sum(u_out_sum), .out_valid(u_out_valid), .out_ready(out_ready));

   pipelined_adder_tree #(.ADDER_WIDTH(W), .NUM_INPUTS(N), .SIGNED(1), .ACCUMULATE(0)) dut_s (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(tree_last),
      .in_ready(s_in_ready), .out_sum(s_out_sum), .out_valid(s_out_valid), .out_ready(out_ready));

   pipelined_adder_tree #(.ADDER_WIDTH(W), .NUM_INPUTS(N), .SIGNED(0), .ACCUMULATE(1),
                          .ACC_EXTRA(8)) dut_a (
      .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_last(a_in_last),
      .in_ready(a_in_ready), .out_sum(a_out_sum), .out_valid(a_out_valid), .out_ready(a_out_ready));

   // ---------------- scoreboard ----------------
   logic [TW-1:0] exp_u_q[$];
   logic [TW-1:0] exp_s_q[$];
   logic [AW-1:0] exp_a_q[$];
   longint        frame_sum = 0;
   int            n_checks  = 0;
   int            n_fail    = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: plain sum of the eight lanes, each read as signed or unsigned.
   function automatic longint lane_total(input logic [DW-1:0] d, input bit sgn);
      longint s;
      longint lane;
      s = 0;
      for (int i = 0; i < N; i++) begin
         lane = longint'(d[i*W +: W]);
         if (sgn && d[i*W + W - 1]) lane = lane - 32768;
         s = s + lane;
      end
      return s;
   endfunction

   function automatic logic [TW-1:0] model_tree(input logic [DW-1:0] d, input bit sgn);
      longint s;
      s = lane_total(d, sgn);
      return s[TW-1:0];
   endfunction

   function automatic logic [DW-1:0] rand_data();
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      return r[DW-1:0];
   endfunction

   function automatic logic [DW-1:0] alt_lanes(input logic [W-1:0] even, input logic [W-1:0] odd);
      logic [DW-1:0] d;
      for (int i = 0; i < N; i++) d[i*W +: W] = (i % 2 == 0) ? even : odd;
      return d;
   endfunction

   function automatic logic [DW-1:0] lane0(input logic [W-1:0] v);
      logic [DW-1:0] d;
      d = '0;
      d[W-1:0] = v;
      return d;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic send_tree(input logic [DW-1:0] d);
      int  guard;
      bit  done;
      guard = 0;
      done  = 0;
      while (!done) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = d;
         #1;
         if (u_in_ready) begin
            exp_u_q.push_back(model_tree(d, 1'b0));
            exp_s_q.push_back(model_tree(d, 1'b1));
            done = 1;
         end else begin
            guard++;
            if (guard > 200) begin
               check("send_tree_timeout", 64'(u_in_ready), 64'd1);
               done = 1;
            end
         end
         @(posedge clk);
      end
   endtask

   task automatic idle_tree();
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = rand_data();
   endtask

   task automatic send_acc(input logic [DW-1:0] d, input bit last);
      int       guard;
      bit       done;
      logic [AW-1:0] fs;
      guard = 0;
      done  = 0;
      while (!done) begin
         @(negedge clk);
         a_in_valid = 1'b1;
         a_in_data  = d;
         a_in_last  = last;
         #1;
         if (a_in_ready) begin
            frame_sum = frame_sum + lane_total(d, 1'b0);
            if (last) begin
               fs = frame_sum[AW-1:0];
               exp_a_q.push_back(fs);
               frame_sum = 0;
            end
            done = 1;
         end else begin
            guard++;
            if (guard > 200) begin
               check("send_acc_timeout", 64'(a_in_ready), 64'd1);
               done = 1;
            end
         end
         @(posedge clk);
      end
   endtask

   task automatic idle_acc();
      @(negedge clk);
      a_in_valid = 1'b0;
      a_in_last  = 1'b0;
      a_in_data  = rand_data();
   endtask

   task automatic drain(input string tag);
      int g;
      g = 0;
      while ((exp_u_q.size() + exp_s_q.size() + exp_a_q.size()) != 0 && g < 300) begin
         @(negedge clk);
         g++;
      end
      repeat (3) @(negedge clk);
      check({tag, "_drain_u"}, 64'(exp_u_q.size()), 64'd0);
      check({tag, "_drain_s"}, 64'(exp_s_q.size()), 64'd0);
      check({tag, "_drain_a"}, 64'(exp_a_q.size()), 64'd0);
   endtask

   task automatic check_reset_outputs();
      check("rst_u_sum",   64'(u_out_sum),   64'd0);
      check("rst_u_valid", 64'(u_out_valid), 64'd0);
      check("rst_u_ready", 64'(u_in_ready),  64'd1);
      check("rst_s_sum",   64'(s_out_sum),   64'd0);
      check("rst_s_valid", 64'(s_out_valid), 64'd0);
      check("rst_s_ready", 64'(s_in_ready),  64'd1);
      check("rst_a_sum",   64'(a_out_sum),   64'd0);
      check("rst_a_valid", 64'(a_out_valid), 64'd0);
      check("rst_a_ready", 64'(a_in_ready),  64'd1);
   endtask

   // ---------------- monitors (sample late in the low phase) ----------------
   always @(negedge clk) begin
      #3;
      if (!rst) begin
         check("u_in_ready_rule", 64'(u_in_ready), 64'(out_ready || !u_out_valid));
         if (u_out_valid && out_ready) begin
            if (exp_u_q.size() == 0) check("u_unexpected_out", 64'(u_out_valid), 64'd0);
            else check("u_sum", 64'(u_out_sum), 64'(exp_u_q.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      #3;
      if (!rst) begin
         check("s_in_ready_rule", 64'(s_in_ready), 64'(out_ready || !s_out_valid));
         if (s_out_valid && out_ready) begin
            if (exp_s_q.size() == 0) check("s_unexpected_out", 64'(s_out_valid), 64'd0);
            else check("s_sum", 64'(s_out_sum), 64'(exp_s_q.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      #3;
      if (!rst) begin
         check("a_in_ready_rule", 64'(a_in_ready), 64'(a_out_ready || !a_out_valid));
         if (a_out_valid && a_out_ready) begin
            if (exp_a_q.size() == 0) check("a_unexpected_out", 64'(a_out_valid), 64'd0);
            else check("a_sum", 64'(a_out_sum), 64'(exp_a_q.pop_front()));
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      #2;
      check_reset_outputs();
      @(negedge clk);
      rst = 1'b0;

      // Unsigned full scale with latency check
      send_tree(alt_lanes(15'h7fff, 15'h7fff));
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      check("lat_edge_t", 64'(u_out_valid), 64'd0);
      @(negedge clk); #2;
      check("lat_edge_t1", 64'(u_out_valid), 64'd0);
      @(negedge clk); #2;
      check("lat_edge_t2", 64'(u_out_valid), 64'd0);
      @(negedge clk); #2;
      check("lat_edge_t3", 64'(u_out_valid), 64'd1);
      check("full_scale_sum", 64'(u_out_sum), 64'd262136);

      // Signed patterns
      send_tree(alt_lanes(15'h4000, 15'h4000));
      send_tree(alt_lanes(15'd5, 15'h7ffd));
      idle_tree();
      drain("signed");

      // Back-to-back 1,2,3,4 with a 3-cycle stall after the first result
      fork
         begin
            for (int k = 1; k <= 4; k++) send_tree(lane0(W'(k)));
            idle_tree();
         end
         begin
            int g;
            g = 0;
            do begin
               @(negedge clk);
               #2;
               g++;
            end while (!u_out_valid && g < 50);
            check("stall_first_valid", 64'(u_out_valid), 64'd1);
            for (int j = 0; j < 3; j++) begin
               @(negedge clk);
               out_ready = 1'b0;
               #2;
               check("stall_in_ready",  64'(u_in_ready),  64'd0);
               check("stall_valid",     64'(u_out_valid), 64'd1);
               check("stall_u_stable",  64'(u_out_sum),   64'(exp_u_q[0]));
               check("stall_s_stable",  64'(s_out_sum),   64'(exp_s_q[0]));
            end
            @(negedge clk);
            out_ready = 1'b1;
         end
      join
      drain("stall");

      // Accumulate: frame 10+20+30, then single-beat frame 7
      send_acc(lane0(15'd10), 1'b0);
      send_acc(lane0(15'd20), 1'b0);
      send_acc(lane0(15'd30), 1'b1);
      idle_acc();
      send_acc(lane0(15'd7), 1'b1);
      idle_acc();
      drain("acc_directed");

      // Randomized beats, frames and backpressure on all instances
      fork
         begin
            for (int i = 0; i < 30; i++) begin
               if ($urandom_range(0, 3) == 0) idle_tree();
               send_tree(rand_data());
            end
            idle_tree();
         end
         begin
            for (int i = 0; i < 30; i++) begin
               if ($urandom_range(0, 3) == 0) idle_acc();
               send_acc(rand_data(), (i == 29) || ($urandom_range(0, 2) == 0));
            end
            idle_acc();
         end
         begin
            repeat (120) begin
               @(negedge clk);
               out_ready   = ($urandom_range(0, 3) != 0);
               a_out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready   = 1'b1;
            a_out_ready = 1'b1;
         end
      join
      drain("random");

      // Reset with two tree beats in flight and a half-accumulated frame
      fork
         begin
            send_tree(lane0(15'd3));
            send_tree(lane0(15'd4));
         end
         begin
            send_acc(lane0(15'd10), 1'b0);
            send_acc(lane0(15'd11), 1'b0);
         end
      join
      @(negedge clk);
      rst        = 1'b1;
      in_valid   = 1'b0;
      a_in_valid = 1'b0;
      a_in_last  = 1'b0;
      exp_u_q.delete();
      exp_s_q.delete();
      exp_a_q.delete();
      frame_sum = 0;
      @(negedge clk);
      #2;
      check_reset_outputs();
      @(negedge clk);
      rst = 1'b0;
      fork
         send_tree(lane0(15'd5));
         send_acc(lane0(15'd5), 1'b1);
      join
      fork
         idle_tree();
         idle_acc();
      join
      drain("post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
